// File: rtl/fwdk2j.sv
// Two-joint planar forward kinematics using one shared iterative CORDIC rotator.
// Define FWDK2J_ROUND_EN to round each CORDIC shift term half-up instead of truncating.
module fwdk2j #(
    parameter logic [31:0] L1   = 32'h0000_8000,
    parameter logic [31:0] L2   = 32'h0000_8000,
    parameter int          ITER = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out0,
    output logic [31:0] out1,
    output logic        out_valid
);

    typedef enum logic [2:0] {IDLE, PREP1, ROT1, PREP2, ROT2, ACC} state_t;

    localparam logic signed [33:0] PI  = 34'sd205887;
    localparam logic signed [33:0] HPI = 34'sd102944;
    localparam logic signed [33:0] TPI = 34'sd411775;
    localparam logic [4:0]         LAST = 5'(ITER - 1);

    // Start magnitudes are pre-divided by the CORDIC gain so no final scaling is needed.
    localparam longint KL1_L = (longint'(L1) * 64'sd607253 + 64'sd500000) / 64'sd1000000;
    localparam longint KL2_L = (longint'(L2) * 64'sd607253 + 64'sd500000) / 64'sd1000000;
    localparam logic signed [33:0] KL1 = 34'(KL1_L);
    localparam logic signed [33:0] KL2 = 34'(KL2_L);

    function automatic logic signed [33:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:    return 34'sd51472;
            5'd1:    return 34'sd30386;
            5'd2:    return 34'sd16055;
            5'd3:    return 34'sd8150;
            5'd4:    return 34'sd4091;
            5'd5:    return 34'sd2047;
            5'd6:    return 34'sd1024;
            5'd7:    return 34'sd512;
            5'd8:    return 34'sd256;
            5'd9:    return 34'sd128;
            5'd10:   return 34'sd64;
            5'd11:   return 34'sd32;
            5'd12:   return 34'sd16;
            5'd13:   return 34'sd8;
            5'd14:   return 34'sd4;
            5'd15:   return 34'sd2;
            default: return 34'sd0;
        endcase
    endfunction

    function automatic logic signed [33:0] shr(input logic signed [33:0] v, input logic [4:0] i);
`ifdef FWDK2J_ROUND_EN
        logic signed [33:0] bias;
        bias = (i == 5'd0) ? 34'sd0 : (34'sd1 <<< (i - 5'd1));
        return (v + bias) >>> i;
`else
        return v >>> i;
`endif
    endfunction

    state_t             state, state_next;
    logic [4:0]         cnt;
    logic signed [33:0] x, y, z;
    logic signed [33:0] a1, a2;
    logic [31:0]        ax, ay;
    logic               neg;

    logic signed [33:0] ang, wrapped, folded;
    logic               fneg;
    logic signed [33:0] xs, ys, xn, yn, zn;
    logic               dpos;

    // Fold the pending angle into [-pi/2, pi/2]; the half-turn is undone by negating the pass result.
    always_comb begin
        ang = (state == PREP2) ? a2 : a1;
        wrapped = ang;
        if (ang > PI)
            wrapped = ang - TPI;
        else if (ang < -PI)
            wrapped = ang + TPI;
        folded = wrapped;
        fneg = 1'b0;
        if (wrapped > HPI) begin
            folded = wrapped - PI;
            fneg = 1'b1;
        end else if (wrapped < -HPI) begin
            folded = wrapped + PI;
            fneg = 1'b1;
        end
    end

    always_comb begin
        dpos = ~z[33];
        xs = shr(x, cnt);
        ys = shr(y, cnt);
        xn = dpos ? (x - ys) : (x + ys);
        yn = dpos ? (y + xs) : (y - xs);
        zn = dpos ? (z - atan_lut(cnt)) : (z + atan_lut(cnt));
    end

    always_comb begin
        state_next = state;
        in_ready = (state == IDLE);
        case (state)
            IDLE:    if (in_valid) state_next = PREP1;
            PREP1:   state_next = ROT1;
            ROT1:    if (cnt == LAST) state_next = PREP2;
            PREP2:   state_next = ROT2;
            ROT2:    if (cnt == LAST) state_next = ACC;
            ACC:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            a1        <= '0;
            a2        <= '0;
            ax        <= '0;
            ay        <= '0;
            neg       <= 1'b0;
            out0      <= '0;
            out1      <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a1 <= {{2{in0[31]}}, in0};
                        a2 <= {{2{in0[31]}}, in0} + {{2{in1[31]}}, in1};
                    end
                end
                PREP1: begin
                    x   <= KL1;
                    y   <= '0;
                    z   <= folded;
                    neg <= fneg;
                    cnt <= 5'd0;
                end
                ROT1, ROT2: begin
                    x   <= xn;
                    y   <= yn;
                    z   <= zn;
                    cnt <= cnt + 5'd1;
                end
                PREP2: begin
                    // The old neg still applies to the link-1 partial sums captured here.
                    ax  <= neg ? -x[31:0] : x[31:0];
                    ay  <= neg ? -y[31:0] : y[31:0];
                    x   <= KL2;
                    y   <= '0;
                    z   <= folded;
                    neg <= fneg;
                    cnt <= 5'd0;
                end
                ACC: begin
                    out0      <= neg ? (ax - x[31:0]) : (ax + x[31:0]);
                    out1      <= neg ? (ay - y[31:0]) : (ay + y[31:0]);
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fwdk2j.sv
// Self-checking bench for fwdk2j: ideal trig model feeds a scoreboard queue,
// a negedge monitor pops and compares every out_valid pulse.
module tb_fwdk2j;

    localparam logic [31:0] L1 = 32'h0000_8000;
    localparam logic [31:0] L2 = 32'h0000_8000;
    localparam int TOL = 16;
    localparam int LAT = 36;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in0, in1;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0, out1;
    logic        out_valid;

    typedef struct packed {
        int ex;
        int ey;
        int due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   ovpulses = 0;
    int   mon_d;

    fwdk2j #(.L1(L1), .L2(L2), .ITER(16)) dut (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in_valid(in_valid),
        .in_ready(in_ready), .out0(out0), .out1(out1), .out_valid(out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ideal(input bit isy, input logic [31:0] t1, input logic [31:0] t2);
        real a, b, l1, l2, v;
        a  = $itor($signed(t1)) / 65536.0;
        b  = a + $itor($signed(t2)) / 65536.0;
        l1 = $itor(L1) / 65536.0;
        l2 = $itor(L2) / 65536.0;
        v  = isy ? (l1 * $sin(a) + l2 * $sin(b)) : (l1 * $cos(a) + l2 * $cos(b));
        v  = v * 65536.0;
        return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    endfunction

    // Every result pulse must match the oldest outstanding operation in value and timing.
    always @(negedge clk) begin
        if (out_valid) begin
            ovpulses++;
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_out_valid at cyc=%0d, required no pulse", cyc);
            end else begin
                mon_e = sbq.pop_front();
                vectors++;
                mon_d = $signed(out0) - mon_e.ex;
                if (mon_d > TOL || mon_d < -TOL) begin
                    miscompares++;
                    $display("[TB] FAIL x got=%0d required=%0d+-%0d", $signed(out0), mon_e.ex, TOL);
                end
                vectors++;
                mon_d = $signed(out1) - mon_e.ey;
                if (mon_d > TOL || mon_d < -TOL) begin
                    miscompares++;
                    $display("[TB] FAIL y got=%0d required=%0d+-%0d", $signed(out1), mon_e.ey, TOL);
                end
                vectors++;
                if (cyc !== mon_e.due) begin
                    miscompares++;
                    $display("[TB] FAIL latency cyc got=%0d required=%0d", cyc, mon_e.due);
                end
            end
        end
    end

    // Presents one operation, pushes its expectation, scrambles the inputs after the transfer.
    task automatic issue(input logic [31:0] t1, input logic [31:0] t2, input bit hold, output int n);
        int k;
        in0 = t1;
        in1 = t2;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL in_ready_timeout got=0 required=1");
            in_valid = 1'b0;
            n = -1;
            return;
        end
        n = cyc;
        sbq.push_back('{ex: ideal(1'b0, t1, t2), ey: ideal(1'b1, t1, t2), due: cyc + LAT});
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        in0 = $urandom;
        in1 = $urandom;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        in0 = '0;
        in1 = '0;
        repeat (10) @(negedge clk);
        vectors++;
        if (out0 !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_out0 got=%0h required=0", out0); end
        vectors++;
        if (out1 !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_out1 got=%0h required=0", out1); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got=%b required=0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got=%b required=1", in_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_corners;
        logic [31:0] ta[6];
        logic [31:0] tb[6];
        int n;
        ta = '{32'd0, 32'd102944, 32'd205887, -32'sd205887, -32'sd102944, 32'd51472};
        tb = '{32'd0, 32'd102944, 32'd205887, -32'sd205887, 32'd205887, -32'sd180000};
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i], 1'b0, n);
            for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
            vectors++;
            if (sbq.size() != 0) begin
                miscompares++;
                $display("[TB] FAIL corner_drain case=%0d pending=%0d required=0", i, sbq.size());
                sbq.delete();
            end
        end
    endtask

    task automatic test_random;
        int n;
        for (int i = 0; i < 8; i++) begin
            issue(32'($urandom_range(0, 411774) - 205887), 32'($urandom_range(0, 411774) - 205887), 1'b0, n);
        end
        for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL random_drain pending=%0d required=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_back_to_back;
        int n, prev;
        issue(32'd30000, 32'd60000, 1'b1, prev);
        for (int i = 1; i < 5; i++) begin
            issue(32'(i * 40000 - 100000), 32'(70000 - i * 30000), 1'b1, n);
            vectors++;
            if (n - prev !== LAT) begin
                miscompares++;
                $display("[TB] FAIL b2b_spacing got=%0d required=%0d", n - prev, LAT);
            end
            prev = n;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_drain pending=%0d required=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_busy_ignored;
        int n, p;
        p = ovpulses;
        issue(32'd12345, -32'sd54321, 1'b0, n);
        for (int i = 0; i < 6; i++) begin
            repeat (2) @(negedge clk);
            in0 = $urandom;
            in1 = $urandom;
            in_valid = 1'b1;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL busy_in_ready got=%b required=0", in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
        repeat (40) @(negedge clk);
        vectors++;
        if (ovpulses - p !== 1) begin
            miscompares++;
            $display("[TB] FAIL busy_pulse_count got=%0d required=1", ovpulses - p);
        end
    endtask

    task automatic test_reset_midop;
        int n, p;
        issue(32'd80000, 32'd20000, 1'b0, n);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_in_ready got=%b required=1", in_ready); end
        vectors++;
        if (out0 !== 32'd0) begin miscompares++; $display("[TB] FAIL midrst_out0 got=%0h required=0", out0); end
        vectors++;
        if (out1 !== 32'd0) begin miscompares++; $display("[TB] FAIL midrst_out1 got=%0h required=0", out1); end
        sbq.delete();
        p = ovpulses;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        vectors++;
        if (ovpulses !== p) begin
            miscompares++;
            $display("[TB] FAIL midrst_no_out_valid got=%0d required=0", ovpulses - p);
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_random();
        test_back_to_back();
        test_busy_ignored();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
